// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
// Register indices are stored zero-extended to SB_AW_MAX bits so one entry type serves any REG_AW.
package hazard_scoreboard_pkg;

    localparam int REG_AW_DEF     = 5;
    localparam int LOAD_READY_DEF = 2;
    localparam int SB_AW_MAX      = 8;

    localparam int FWD_RF     = 0;
    localparam int FWD_EX_MEM = 1;
    localparam int FWD_MEM_WB = 2;

    typedef struct packed {
        logic                 valid;
        logic [SB_AW_MAX-1:0] rd;
        logic                 reg_write;
        logic                 is_load;
        logic [SB_AW_MAX-1:0] rs1;
        logic [SB_AW_MAX-1:0] rs2;
        logic                 rs1_used;
        logic                 rs2_used;
    } sb_entry_t;

    // True when entry e produces the value that a used source register src needs; x0 never matches.
    function automatic logic writes_src(input sb_entry_t e,
                                        input logic [SB_AW_MAX-1:0] src,
                                        input logic used);
        return e.valid && e.reg_write && (e.rd == src) && (src != '0) && used;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: count_d gets its hold value before the conditional update so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: flops take <= so every register samples pre-edge values regardless of process order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard controller: shift-register scoreboard from EX to write-back,
// per-operand forward selects, load-use stall, branch flush and saturating perf counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = LOAD_READY_DEF,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    if (LOAD_READY < 1 || LOAD_READY > FWD_DEPTH) begin : g_bad_load_ready
        $error("hazard_scoreboard: LOAD_READY must lie in 1..FWD_DEPTH");
    end
    if (REG_AW > SB_AW_MAX) begin : g_bad_reg_aw
        $error("hazard_scoreboard: REG_AW exceeds scoreboard index width");
    end

    sb_entry_t sb_q [FWD_DEPTH+1];
    sb_entry_t sb_d [FWD_DEPTH+1];
    sb_entry_t id_entry;
    logic      load_use;

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = id_valid;
        id_entry.rd        = SB_AW_MAX'(id_rd);
        id_entry.reg_write = id_reg_write;
        id_entry.is_load   = id_is_load;
        id_entry.rs1       = SB_AW_MAX'(id_rs1);
        id_entry.rs2       = SB_AW_MAX'(id_rs2);
        id_entry.rs1_used  = id_rs1_used;
        id_entry.rs2_used  = id_rs2_used;
    end

    // A load still in entries 0..LOAD_READY-2 cannot feed the ID instruction by the time it reaches EX.
    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < LOAD_READY - 1; j++) begin
            if (sb_q[j].is_load &&
                (writes_src(sb_q[j], id_entry.rs1, id_rs1_used) ||
                 writes_src(sb_q[j], id_entry.rs2, id_rs2_used))) begin
                load_use = 1'b1;
            end
        end
    end

    assign stall       = id_valid & load_use & ~ex_branch_taken;
    assign flush_if_id = ex_branch_taken & reset_n;
    assign flush_id_ex = ex_branch_taken & reset_n;

    // Walk oldest to youngest so the nearest producer overwrites any farther one.
    always_comb begin
        fwd_sel_a = SEL_W'(FWD_RF);
        fwd_sel_b = SEL_W'(FWD_RF);
        for (int k = FWD_DEPTH; k >= FWD_EX_MEM; k--) begin
            if (!(sb_q[k].is_load && (k < LOAD_READY))) begin
                if (writes_src(sb_q[k], sb_q[0].rs1, sb_q[0].rs1_used)) begin
                    fwd_sel_a = SEL_W'(k);
                end
                if (writes_src(sb_q[k], sb_q[0].rs2, sb_q[0].rs2_used)) begin
                    fwd_sel_b = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        sb_d[0] = (id_valid && !stall && !ex_branch_taken) ? id_entry : '0;
    end

    // NOTE: the scoreboard is a few flops rather than a RAM, so every entry is cleared on reset
    // to guarantee no stale valid bit survives.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall),
        .count   (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush_id_ex),
        .count   (flush_count)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three configurations driven in lockstep, checked against a cycle-log model,
// a directed vector table for the default configuration, and multi-cycle corner sequences.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ins_t;

    typedef struct packed {
        logic        stall;
        logic        fif;
        logic        fex;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sc;
        logic [31:0] fc;
    } obs_t;

    typedef struct {
        ins_t id;
        logic br;
        logic st;
        int   a;
        int   b;
        int   sc;
        int   fc;
    } vec_t;

    localparam int LOG_N = 2048;
    localparam int N_VEC = 24;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, ex_branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall0, fif0, fex0, stall1, fif1, fex1, stall2, fif2, fex2;
    logic [1:0]  sa0, sb0, sa1, sb1, sa2, sb2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    obs_t obs [3];
    obs_t last_obs [3];
    logic last_stall [3];

    ins_t ex_log [3][LOG_N];
    int   s_cnt [3];
    int   f_cnt [3];
    int   n;
    int   tests;
    int   fails;
    vec_t tbl [N_VEC];

    always #5 clock = ~clock;

    hazard_scoreboard u_dut0 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall(stall0), .flush_if_id(fif0), .flush_id_ex(fex0), .fwd_sel_a(sa0), .fwd_sel_b(sb0),
        .stall_count(sc0), .flush_count(fc0)
    );

    hazard_scoreboard #(.FWD_DEPTH(3), .LOAD_READY(3)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall(stall1), .flush_if_id(fif1), .flush_id_ex(fex1), .fwd_sel_a(sa1), .fwd_sel_b(sb1),
        .stall_count(sc1), .flush_count(fc1)
    );

    hazard_scoreboard #(.CNT_W(4)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall(stall2), .flush_if_id(fif2), .flush_id_ex(fex2), .fwd_sel_a(sa2), .fwd_sel_b(sb2),
        .stall_count(sc2), .flush_count(fc2)
    );

    always_comb begin
        obs[0] = '{stall0, fif0, fex0, 32'(sa0), 32'(sb0), 32'(sc0), 32'(fc0)};
        obs[1] = '{stall1, fif1, fex1, 32'(sa1), 32'(sb1), 32'(sc1), 32'(fc1)};
        obs[2] = '{stall2, fif2, fex2, 32'(sa2), 32'(sb2), 32'(sc2), 32'(fc2)};
    end

    function automatic int cfg_depth(input int c);
        return (c == 1) ? 3 : 2;
    endfunction

    function automatic int cfg_lr(input int c);
        return (c == 1) ? 3 : 2;
    endfunction

    function automatic int cfg_max(input int c);
        return (c == 2) ? 15 : 65535;
    endfunction

    function automatic ins_t alu(input int rd, input int rs1, input int rs2);
        ins_t i;
        i = '{1'b1, 5'(rs1), 5'(rs2), 1'b1, 1'b1, 5'(rd), 1'b1, 1'b0};
        return i;
    endfunction

    function automatic ins_t addi(input int rd, input int rs1);
        ins_t i;
        i = '{1'b1, 5'(rs1), 5'd0, 1'b1, 1'b0, 5'(rd), 1'b1, 1'b0};
        return i;
    endfunction

    function automatic ins_t lw(input int rd, input int rs1);
        ins_t i;
        i = '{1'b1, 5'(rs1), 5'd0, 1'b1, 1'b0, 5'(rd), 1'b1, 1'b1};
        return i;
    endfunction

    // rs1 field carries rd bits but is marked unused, as in a real U-type encoding.
    function automatic ins_t lui(input int rd);
        ins_t i;
        i = '{1'b1, 5'(rd), 5'd0, 1'b0, 1'b0, 5'(rd), 1'b1, 1'b0};
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.v   = ($urandom_range(0, 9) < 8);
        i.rs1 = 5'($urandom_range(0, 3));
        i.rs2 = 5'($urandom_range(0, 3));
        i.u1  = ($urandom_range(0, 3) != 0);
        i.u2  = ($urandom_range(0, 3) != 0);
        i.rd  = 5'($urandom_range(0, 3));
        i.ld  = ($urandom_range(0, 3) == 0);
        i.we  = i.ld ? 1'b1 : ($urandom_range(0, 4) != 0);
        return i;
    endfunction

    function automatic ins_t ex_at(input int c, input int cyc);
        if (cyc < 0) return '0;
        return ex_log[c][cyc];
    endfunction

    function automatic logic produces(input ins_t e, input logic [4:0] src, input logic used);
        return e.v && e.we && (e.rd == src) && (src != 5'd0) && used;
    endfunction

    // Reference: the instruction that entered EX j cycles ago sits at distance j.
    task automatic ref_outputs(input int c, input ins_t id, input logic br,
                               output logic st, output int a, output int b);
        ins_t ex;
        ex = ex_at(c, n);
        st = 1'b0;
        a  = 0;
        b  = 0;
        for (int j = 0; j <= cfg_lr(c) - 2; j++) begin
            ins_t e;
            e = ex_at(c, n - j);
            if (e.ld && (produces(e, id.rs1, id.u1) || produces(e, id.rs2, id.u2))) st = 1'b1;
        end
        st = st && id.v && !br;
        for (int k = 1; k <= cfg_depth(c); k++) begin
            ins_t e;
            e = ex_at(c, n - k);
            if (!(e.ld && k < cfg_lr(c))) begin
                if (a == 0 && produces(e, ex.rs1, ex.u1)) a = k;
                if (b == 0 && produces(e, ex.rs2, ex.u2)) b = k;
            end
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < LOG_N; i++) ex_log[c][i] = '0;
            s_cnt[c] = 0;
            f_cnt[c] = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t id, input logic br);
        id_valid        = id.v;
        id_rs1          = id.rs1;
        id_rs2          = id.rs2;
        id_rs1_used     = id.u1;
        id_rs2_used     = id.u2;
        id_rd           = id.rd;
        id_reg_write    = id.we;
        id_is_load      = id.ld;
        ex_branch_taken = br;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input ins_t id, input logic br);
        logic st [3];
        int   a;
        int   b;
        drive(id, br);
        #1;
        for (int c = 0; c < 3; c++) begin
            ref_outputs(c, id, br, st[c], a, b);
            check($sformatf("c%0d_t%0d_stall", c, n), 32'(obs[c].stall), 32'(st[c]));
            check($sformatf("c%0d_t%0d_flush_if_id", c, n), 32'(obs[c].fif), 32'(br));
            check($sformatf("c%0d_t%0d_flush_id_ex", c, n), 32'(obs[c].fex), 32'(br));
            check($sformatf("c%0d_t%0d_fwd_a", c, n), obs[c].a, 32'(a));
            check($sformatf("c%0d_t%0d_fwd_b", c, n), obs[c].b, 32'(b));
            check($sformatf("c%0d_t%0d_stall_count", c, n), obs[c].sc, 32'(s_cnt[c]));
            check($sformatf("c%0d_t%0d_flush_count", c, n), obs[c].fc, 32'(f_cnt[c]));
            last_obs[c]   = obs[c];
            last_stall[c] = obs[c].stall;
        end
        @(posedge clock);
        for (int c = 0; c < 3; c++) begin
            ex_log[c][n+1] = (id.v && !st[c] && !br) ? id : '0;
            if (st[c] && s_cnt[c] < cfg_max(c)) s_cnt[c]++;
            if (br && f_cnt[c] < cfg_max(c)) f_cnt[c]++;
        end
        n++;
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s_c%0d_stall", tag, c), 32'(obs[c].stall), 0);
            check($sformatf("%s_c%0d_flush_if_id", tag, c), 32'(obs[c].fif), 0);
            check($sformatf("%s_c%0d_flush_id_ex", tag, c), 32'(obs[c].fex), 0);
            check($sformatf("%s_c%0d_fwd_a", tag, c), obs[c].a, 0);
            check($sformatf("%s_c%0d_fwd_b", tag, c), obs[c].b, 0);
            check($sformatf("%s_c%0d_stall_count", tag, c), obs[c].sc, 0);
            check($sformatf("%s_c%0d_flush_count", tag, c), obs[c].fc, 0);
        end
    endtask

    task automatic pulse_reset();
        drive(alu(1, 1, 1), 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        drive('0, 1'b0);
        clear_model();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, expected completion earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int ns;
        tests = 0;
        fails = 0;
        n     = 0;

        //            id              br    st    a  b  sc fc
        tbl[0]  = '{alu(5, 1, 2),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{alu(6, 5, 1),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[2]  = '{ins_t'(0),        1'b0, 1'b0, 1, 0, 0, 0};
        tbl[3]  = '{alu(5, 3, 4),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[4]  = '{ins_t'(0),        1'b0, 1'b0, 0, 0, 0, 0};
        tbl[5]  = '{alu(7, 5, 5),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[6]  = '{ins_t'(0),        1'b0, 1'b0, 2, 2, 0, 0};
        tbl[7]  = '{alu(5, 1, 1),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[8]  = '{alu(5, 2, 2),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[9]  = '{alu(8, 5, 5),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[10] = '{ins_t'(0),        1'b0, 1'b0, 1, 1, 0, 0};
        tbl[11] = '{addi(0, 1),       1'b0, 1'b0, 0, 0, 0, 0};
        tbl[12] = '{alu(9, 0, 0),     1'b0, 1'b0, 0, 0, 0, 0};
        tbl[13] = '{ins_t'(0),        1'b0, 1'b0, 0, 0, 0, 0};
        tbl[14] = '{lw(5, 1),         1'b0, 1'b0, 0, 0, 0, 0};
        tbl[15] = '{alu(6, 5, 0),     1'b0, 1'b1, 0, 0, 0, 0};
        tbl[16] = '{alu(6, 5, 0),     1'b0, 1'b0, 0, 0, 1, 0};
        tbl[17] = '{ins_t'(0),        1'b0, 1'b0, 2, 0, 1, 0};
        tbl[18] = '{lw(5, 2),         1'b0, 1'b0, 0, 0, 1, 0};
        tbl[19] = '{lui(5),           1'b0, 1'b0, 0, 0, 1, 0};
        tbl[20] = '{ins_t'(0),        1'b0, 1'b0, 0, 0, 1, 0};
        tbl[21] = '{lw(10, 1),        1'b0, 1'b0, 0, 0, 1, 0};
        tbl[22] = '{alu(11, 10, 10),  1'b1, 1'b0, 0, 0, 1, 0};
        tbl[23] = '{ins_t'(0),        1'b0, 1'b0, 0, 0, 1, 1};

        reset_n = 1'b0;
        drive(alu(1, 1, 1), 1'b0);
        clear_model();
        #2;
        check_all_zero("reset");
        drive('0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            step(tbl[i].id, tbl[i].br);
            check($sformatf("vec%0d_stall", i), 32'(last_obs[0].stall), 32'(tbl[i].st));
            check($sformatf("vec%0d_flush", i), 32'(last_obs[0].fex), 32'(tbl[i].br));
            check($sformatf("vec%0d_fwd_a", i), last_obs[0].a, 32'(tbl[i].a));
            check($sformatf("vec%0d_fwd_b", i), last_obs[0].b, 32'(tbl[i].b));
            check($sformatf("vec%0d_stall_count", i), last_obs[0].sc, 32'(tbl[i].sc));
            check($sformatf("vec%0d_flush_count", i), last_obs[0].fc, 32'(tbl[i].fc));
        end

        // Deeper load latency: the dependent add must wait two cycles, then forward from entry 3.
        repeat (3) step('0, 1'b0);
        step(lw(5, 1), 1'b0);
        ns = 0;
        for (int i = 0; i < 8; i++) begin
            step(alu(6, 5, 0), 1'b0);
            if (last_stall[1]) ns++;
            else break;
        end
        check("lr3_stall_cycles", 32'(ns), 2);
        step('0, 1'b0);
        check("lr3_fwd_a", last_obs[1].a, 3);

        // Flush counter saturation on the 4-bit instance.
        repeat (20) step('0, 1'b1);
        step('0, 1'b0);
        check("sat_flush_count_w4", last_obs[2].fc, 15);

        repeat (300) step(rnd_ins(), ($urandom_range(0, 9) == 0));
        pulse_reset();
        repeat (100) step(rnd_ins(), ($urandom_range(0, 9) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
